// File: rtl/rc4_ui_pkg.sv
// rc4_ui_pkg: shared state type and key geometry for the RC4 front-panel key entry
package rc4_ui_pkg;
    typedef enum logic [1:0] {EDIT = 2'd0, REQ = 2'd1, RUN = 2'd2} key_entry_state_t;
    localparam int KEY_NIBBLES = 6;
    localparam int KEY_WIDTH = 24;
endpackage

// File: rtl/key_entry_ctrl_if.sv
// key_entry_ctrl_if: panel inputs, core handshake and key/cursor outputs of key_entry_ctrl
//   master: the key entry controller (drives secret_key, cursor, start, busy)
//   slave : the panel/core side (drives switches, buttons, start_ack, done)
interface key_entry_ctrl_if;
    import rc4_ui_pkg::*;
    logic [3:0]           sw_nibble;
    logic                 btn_load_n;
    logic                 btn_next_n;
    logic                 btn_start_n;
    logic                 start_ack;
    logic                 done;
    logic [KEY_WIDTH-1:0] secret_key;
    logic [2:0]           cursor;
    logic                 start;
    logic                 busy;
    modport master (
        input  sw_nibble, btn_load_n, btn_next_n, btn_start_n, start_ack, done,
        output secret_key, cursor, start, busy
    );
    modport slave (
        output sw_nibble, btn_load_n, btn_next_n, btn_start_n, start_ack, done,
        input  secret_key, cursor, start, busy
    );
endinterface

// File: rtl/button_debouncer.sv
// button_debouncer: 2-flop sync + debounce of an active-low button, one-cycle press pulse
//   clk, rst : clock, async active-high reset
//   btn_n_i  : raw active-low button
//   press_o  : registered pulse on the debounced 1->0 transition
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n_i,
    output logic press_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d, last_q, press_q;
    // The level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing sample
    always_comb begin
        cnt_d   = (sync_q[1] == level_q || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        level_d = (sync_q[1] != level_q && cnt_q == LAST) ? sync_q[1] : level_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b1;
            last_q  <= 1'b1;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_n_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            last_q  <= level_q;
            press_q <= last_q & ~level_q;
        end
    end
    assign press_o = press_q;
endmodule

// File: rtl/key_entry_ctrl.sv
// key_entry_ctrl: builds a 24-bit key nibble by nibble and hands it to the RC4 core
//   orig_clk, Reset : clock, async active-high reset
//   bus (master)    : switches/buttons and start_ack/done in; secret_key, cursor, start, busy out
module key_entry_ctrl
    import rc4_ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic orig_clk,
    input  logic Reset,
    key_entry_ctrl_if.master bus
);
    logic load_ev, next_ev, start_ev;
    key_entry_state_t state_q, state_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic [2:0] cursor_q, cursor_d;
    logic start_q, busy_q;
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
        .clk(orig_clk), .rst(Reset), .btn_n_i(bus.btn_load_n), .press_o(load_ev)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk(orig_clk), .rst(Reset), .btn_n_i(bus.btn_next_n), .press_o(next_ev)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
        .clk(orig_clk), .rst(Reset), .btn_n_i(bus.btn_start_n), .press_o(start_ev)
    );
    // Events outside EDIT are dropped; the write always uses the pre-advance cursor
    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        cursor_d = cursor_q;
        case (state_q)
            EDIT: begin
                if (load_ev) key_d[{cursor_q, 2'b00} +: 4] = bus.sw_nibble;
                if (next_ev) cursor_d = (cursor_q == 3'(KEY_NIBBLES - 1)) ? 3'd0 : cursor_q + 3'd1;
                if (start_ev) state_d = REQ;
            end
            REQ:     state_d = bus.start_ack ? RUN : REQ;
            RUN:     state_d = bus.done ? EDIT : RUN;
            default: state_d = EDIT;
        endcase
    end
    always_ff @(posedge orig_clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= EDIT;
            key_q    <= '0;
            cursor_q <= 3'd0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            cursor_q <= cursor_d;
            start_q  <= (state_d == REQ);
            busy_q   <= (state_d != EDIT);
        end
    end
    assign bus.secret_key = key_q;
    assign bus.cursor     = cursor_q;
    assign bus.start      = start_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_key_entry_ctrl.sv
// tb_key_entry_ctrl: randomized directed checks of key_entry_ctrl against a nibble-array model
module tb_key_entry_ctrl;
    logic orig_clk = 1'b0;
    logic Reset;
    int n_tests = 0;
    int n_fail = 0;
    logic [3:0] m_key [6];
    int m_cur;
    bit m_start, m_busy;

    key_entry_ctrl_if bus();
    key_entry_ctrl #(.DEBOUNCE_CYCLES(4)) dut (.orig_clk(orig_clk), .Reset(Reset), .bus(bus));

    always #5 orig_clk = ~orig_clk;

    function automatic logic [23:0] mkey();
        logic [23:0] r;
        for (int i = 0; i < 6; i++) r[i*4 +: 4] = m_key[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_key[i] = 4'h0;
        m_cur = 0;
        m_start = 0;
        m_busy = 0;
    endtask

    // Spec rules for a press event arriving in the model
    task automatic model_event(input bit l, input bit n, input bit s);
        if (!m_busy) begin
            if (l) m_key[m_cur] = bus.sw_nibble;
            if (n) m_cur = (m_cur + 1) % 6;
            if (s) begin
                m_start = 1;
                m_busy = 1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "/key"}, 32'(bus.secret_key), 32'(mkey()));
        check({tag, "/cursor"}, 32'(bus.cursor), 32'(m_cur));
        check({tag, "/start"}, 32'(bus.start), 32'(m_start));
        check({tag, "/busy"}, 32'(bus.busy), 32'(m_busy));
    endtask

    // Raw edge at a negedge: nothing visible after 7 edges, effect lands on edge 8
    task automatic press(input string tag, input bit l, input bit n, input bit s);
        bus.btn_load_n = !l;
        bus.btn_next_n = !n;
        bus.btn_start_n = !s;
        repeat (7) @(negedge orig_clk);
        check_all({tag, "/early"});
        @(negedge orig_clk);
        model_event(l, n, s);
        check_all({tag, "/edge8"});
        repeat (2) @(negedge orig_clk);
        bus.btn_load_n = 1'b1;
        bus.btn_next_n = 1'b1;
        bus.btn_start_n = 1'b1;
        repeat (10) @(negedge orig_clk);
        check_all({tag, "/settled"});
    endtask

    task automatic ack(input string tag);
        bus.start_ack = 1'b1;
        @(negedge orig_clk);
        bus.start_ack = 1'b0;
        if (m_start) m_start = 0;
        check_all(tag);
    endtask

    task automatic done_pulse(input string tag);
        bus.done = 1'b1;
        @(negedge orig_clk);
        bus.done = 1'b0;
        if (m_busy && !m_start) m_busy = 0;
        check_all(tag);
    endtask

    initial begin
        Reset = 1'b1;
        bus.sw_nibble = 4'h0;
        bus.btn_load_n = 1'b1;
        bus.btn_next_n = 1'b1;
        bus.btn_start_n = 1'b1;
        bus.start_ack = 1'b0;
        bus.done = 1'b0;
        model_reset();
        repeat (3) @(negedge orig_clk);
        check_all("reset");
        Reset = 1'b0;
        repeat (12) @(negedge orig_clk);
        check_all("post_reset");

        // Bounces of 3 cycles must never register
        bus.sw_nibble = 4'hA;
        repeat (5) begin
            bus.btn_load_n = 1'b0;
            repeat (3) @(negedge orig_clk);
            bus.btn_load_n = 1'b1;
            repeat (3) @(negedge orig_clk);
        end
        repeat (6) @(negedge orig_clk);
        check_all("glitch");

        // Exact latency on a long press of 0xA
        press("latency", 1, 0, 0);
        check("latency_nib0", 32'(bus.secret_key[3:0]), 32'hA);

        // Full key entry with a wrapping sixth next
        for (int i = 0; i < 6; i++) begin
            bus.sw_nibble = 4'(10 + i);
            press("entry_load", 1, 0, 0);
            press("entry_next", 0, 1, 0);
        end
        check("full_key", 32'(bus.secret_key), 32'hFEDCBA);
        check("wrap_cursor", 32'(bus.cursor), 32'd0);

        repeat (8) begin
            bus.sw_nibble = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 2))
                0: press("rand_load", 1, 0, 0);
                1: press("rand_next", 0, 1, 0);
                default: press("rand_both", 1, 1, 0);
            endcase
        end

        while (m_cur != 2) press("to_cur2", 0, 1, 0);
        bus.sw_nibble = 4'h7;
        press("load_next", 1, 1, 0);
        check("ln_nib2", 32'(bus.secret_key[11:8]), 32'h7);
        check("ln_cursor", 32'(bus.cursor), 32'd3);

        // Start, held until a delayed ack; done in REQ ignored
        press("start", 0, 0, 1);
        repeat (5) begin
            @(negedge orig_clk);
            check("start_held", 32'(bus.start), 32'd1);
        end
        done_pulse("done_in_req");
        ack("ack");
        bus.sw_nibble = 4'($urandom_range(0, 15));
        press("run_load", 1, 0, 0);
        press("run_next", 0, 1, 0);
        press("run_start", 0, 0, 1);
        ack("ack_in_run");
        done_pulse("done");
        repeat (3) @(negedge orig_clk);
        check_all("no_queued_start");
        done_pulse("done_in_edit");

        // Load event arriving the cycle after busy falls is accepted
        press("start2", 0, 0, 1);
        ack("ack2");
        bus.sw_nibble = 4'($urandom_range(0, 15));
        bus.btn_load_n = 1'b0;
        repeat (6) @(negedge orig_clk);
        bus.done = 1'b1;
        @(negedge orig_clk);
        bus.done = 1'b0;
        m_busy = 0;
        check_all("busy_fall");
        @(negedge orig_clk);
        model_event(1, 0, 0);
        check_all("load_after_done");
        @(negedge orig_clk);
        bus.btn_load_n = 1'b1;
        repeat (10) @(negedge orig_clk);

        // Load and start together: start rises with the new key
        bus.sw_nibble = 4'($urandom_range(0, 15));
        press("load_start", 1, 0, 1);
        ack("ack3");
        done_pulse("done3");

        // Ack already high when start rises: REQ lasts one cycle
        bus.btn_start_n = 1'b0;
        repeat (7) @(negedge orig_clk);
        check_all("early_ack_pre");
        bus.start_ack = 1'b1;
        @(negedge orig_clk);
        model_event(0, 0, 1);
        check_all("early_ack_req");
        @(negedge orig_clk);
        m_start = 0;
        check_all("early_ack_run");
        bus.start_ack = 1'b0;
        bus.btn_start_n = 1'b1;
        repeat (10) @(negedge orig_clk);
        done_pulse("done4");

        // Asynchronous reset in RUN, then a stray done
        press("start5", 0, 0, 1);
        ack("ack5");
        @(posedge orig_clk);
        #2 Reset = 1'b1;
        #1 model_reset();
        check_all("reset_in_run");
        @(negedge orig_clk);
        Reset = 1'b0;
        done_pulse("done_after_reset");
        bus.sw_nibble = 4'($urandom_range(0, 15));
        press("after_reset_load", 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
